// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 raster generator: default timings,
// counter width and the colour-bar palette.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    localparam logic [11:0] C_WHITE   = 12'hFFF;
    localparam logic [11:0] C_YELLOW  = 12'hFF0;
    localparam logic [11:0] C_CYAN    = 12'h0FF;
    localparam logic [11:0] C_GREEN   = 12'h0F0;
    localparam logic [11:0] C_MAGENTA = 12'hF0F;
    localparam logic [11:0] C_RED     = 12'hF00;
    localparam logic [11:0] C_BLUE    = 12'h00F;
    localparam logic [11:0] C_BLACK   = 12'h000;

    // Index 0 is the leftmost bar.
    localparam logic [7:0][11:0] BAR_PALETTE = {C_BLACK, C_BLUE, C_RED, C_MAGENTA,
                                                C_GREEN, C_CYAN, C_YELLOW, C_WHITE};

endpackage

// File: rtl/vga_pattern.sv
// Combinational colour-bar lookup: eight equal-width vertical bars across the
// active line, forced to black outside the visible area.
module vga_pattern
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF
) (
    input  logic [CNT_W-1:0] x,
    input  logic             de,
    output logic [11:0]      rgb
);

    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [2:0] bar;

    always_comb begin
        bar = 3'(x / BAR_W);
        rgb = de ? BAR_PALETTE[bar] : 12'h000;
    end

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator; all outputs are one registered stage
// behind the (hc, vc) counters. Define VGA_TIMING_PATTERN_EN for colour bars on rgb.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   V_FP      = V_FP_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BP      = V_BP_DEF,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic             clock_in,
    input  logic             reset_n,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             line_start,
    output logic [11:0]      rgb
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_size_check
        $error("vga_timing: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    // One extra bit so a sync window ending exactly at 1024 still compares correctly.
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W:0]   H_ACT  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   V_ACT  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   HS_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hc, vc;
    logic [CNT_W:0]   hc_x, vc_x;
    logic             de_n, hs_act, vs_act;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    always_comb begin
        hc_x   = {1'b0, hc};
        vc_x   = {1'b0, vc};
        de_n   = (hc_x < H_ACT) && (vc_x < V_ACT);
        hs_act = (hc_x >= HS_BEG) && (hc_x < HS_END);
        vs_act = (vc_x >= VS_BEG) && (vc_x < VS_END);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            de          <= de_n;
            x           <= hc;
            y           <= vc;
            frame_start <= (hc == '0) && (vc == '0);
            line_start  <= (hc == '0);
        end
    end

`ifdef VGA_TIMING_PATTERN_EN
    logic [11:0] rgb_n;

    vga_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
        .x   (hc),
        .de  (de_n),
        .rgb (rgb_n)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) rgb <= 12'h000;
        else          rgb <= rgb_n;
    end
`else
    assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: a default 640x480 instance plus a tiny-timing instance
// (so whole frames fit in the run) share one clock and a randomly pulsed reset.
module tb_vga_timing;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       ls;
        logic [11:0] rgb;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       d_hs, d_vs, d_de, d_fs, d_ls, s_hs, s_vs, s_de, s_fs, s_ls;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic [11:0] d_rgb, s_rgb;

    vga_timing u_def (
        .clock_in(clk), .reset_n(reset_n), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .x(d_x), .y(d_y), .frame_start(d_fs), .line_start(d_ls), .rgb(d_rgb)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(2)
    ) u_sml (
        .clock_in(clk), .reset_n(reset_n), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .x(s_x), .y(s_y), .frame_start(s_fs), .line_start(s_ls), .rgb(s_rgb)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    pix_t q_def[$];
    pix_t q_sml[$];

    function automatic logic [11:0] bar_color(input int i);
        case (i)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Pixel n clocks after reset release, from plain raster arithmetic.
    function automatic pix_t model(input int cnt, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb);
        pix_t m;
        int ht, vt, p, hx, vy;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = cnt % (ht * vt);
        hx = p % ht;
        vy = p / ht;
        m.de  = (hx < ha) && (vy < va);
        m.hs  = !((hx >= ha + hf) && (hx < ha + hf + hs));
        m.vs  = !((vy >= va + vf) && (vy < va + vf + vs));
        m.x   = 10'(hx);
        m.y   = 10'(vy);
        m.fs  = (p == 0);
        m.ls  = (hx == 0);
`ifdef VGA_TIMING_PATTERN_EN
        m.rgb = m.de ? bar_color(hx / (ha / 8)) : 12'h000;
`else
        m.rgb = 12'h000;
`endif
        return m;
    endfunction

    function automatic pix_t rst_pix();
        pix_t m;
        m     = '0;
        m.hs  = 1'b1;
        m.vs  = 1'b1;
        return m;
    endfunction

    task automatic step(input logic r);
        @(negedge clk);
        reset_n = r;
        if (r) begin
            q_def.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33));
            q_sml.push_back(model(n, 16, 2, 4, 3, 6, 2, 1, 2));
            n++;
        end else begin
            q_def.push_back(rst_pix());
            q_sml.push_back(rst_pix());
            n = 0;
        end
    endtask

    task automatic run(input logic r, input int cycles);
        for (int i = 0; i < cycles; i++) step(r);
    endtask

    always @(posedge clk) begin
        pix_t e, g;
        #1;
        if (q_def.size() > 0) begin
            e = q_def.pop_front();
            g = '{d_hs, d_vs, d_de, d_x, d_y, d_fs, d_ls, d_rgb};
            checks++;
            if (g !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL def_pixel got hs%b vs%b de%b x%0d y%0d fs%b ls%b rgb%h expected hs%b vs%b de%b x%0d y%0d fs%b ls%b rgb%h",
                             g.hs, g.vs, g.de, g.x, g.y, g.fs, g.ls, g.rgb,
                             e.hs, e.vs, e.de, e.x, e.y, e.fs, e.ls, e.rgb);
            end
        end
        if (q_sml.size() > 0) begin
            e = q_sml.pop_front();
            g = '{s_hs, s_vs, s_de, s_x, s_y, s_fs, s_ls, s_rgb};
            checks++;
            if (g !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL sml_pixel got hs%b vs%b de%b x%0d y%0d fs%b ls%b rgb%h expected hs%b vs%b de%b x%0d y%0d fs%b ls%b rgb%h",
                             g.hs, g.vs, g.de, g.x, g.y, g.fs, g.ls, g.rgb,
                             e.hs, e.vs, e.de, e.x, e.y, e.fs, e.ls, e.rgb);
            end
        end
    end

    initial begin
        run(1'b0, 3);
        run(1'b1, 20000);
        for (int k = 0; k < 10; k++) begin
            run(1'b0, $urandom_range(1, 8));
            run(1'b1, $urandom_range(50, 3000));
        end
        run(1'b1, 2000);
        @(posedge clk);
        #2;
        checks++;
        if (q_def.size() != 0 || q_sml.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", q_def.size(), q_sml.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
